// File: rtl/tdm_demux_1_8.sv
// tdm_demux_1_8: receive-side time-division 1:8 demultiplexer.
// Valid slot words are steered into per-slot shadow registers. When slot 7
// arrives, all eight channels are published in parallel together with a
// one-cycle frame strobe. Framing errors (missing or early sync) raise a
// sticky flag.

module tdm_demux_1_8 #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  Clock_In,
    input  logic                  Reset_In,
    input  logic                  Enable_In,
    input  logic [DATA_WIDTH-1:0] Data_In,
    input  logic                  Data_Valid_In,
    input  logic                  Frame_Sync_In,
    input  logic                  Clear_Error_In,
    output logic [DATA_WIDTH-1:0] Data_0_Out,
    output logic [DATA_WIDTH-1:0] Data_1_Out,
    output logic [DATA_WIDTH-1:0] Data_2_Out,
    output logic [DATA_WIDTH-1:0] Data_3_Out,
    output logic [DATA_WIDTH-1:0] Data_4_Out,
    output logic [DATA_WIDTH-1:0] Data_5_Out,
    output logic [DATA_WIDTH-1:0] Data_6_Out,
    output logic [DATA_WIDTH-1:0] Data_7_Out,
    output logic                  Frame_Valid_Out,
    output logic                  Locked_Out,
    output logic [2:0]            Slot_Out,
    output logic                  Sync_Error_Out
);

    typedef enum logic {
        HUNT   = 1'b0,
        LOCKED = 1'b1
    } state_t;

    state_t                state_q, state_d;
    logic [2:0]            slot_q, slot_d;
    logic [DATA_WIDTH-1:0] shadow_q [0:6];
    logic [DATA_WIDTH-1:0] data_q   [0:7];
    logic                  frame_valid_q;
    logic                  sync_error_q;

    logic                  capture;
    logic                  load_word;
    logic [2:0]            load_slot;
    logic                  frame_done;
    logic                  error_set;

    assign capture = Enable_In && Data_Valid_In;

    // State and slot register; reset drops back to hunting at slot 0.
    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            state_q <= HUNT;
            slot_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            slot_q  <= slot_d;
        end
    end

    // Next-state decode: decides where each captured word goes, whether a
    // frame completes, and whether a framing error is detected.
    always_comb begin
        state_d    = state_q;
        slot_d     = slot_q;
        load_word  = 1'b0;
        load_slot  = slot_q;
        frame_done = 1'b0;
        error_set  = 1'b0;
        if (capture) begin
            unique case (state_q)
                HUNT: begin
                    if (Frame_Sync_In) begin
                        state_d   = LOCKED;
                        slot_d    = 3'd1;
                        load_word = 1'b1;
                        load_slot = 3'd0;
                    end
                end
                LOCKED: begin
                    if (Frame_Sync_In) begin
                        // A sync anywhere but slot 0 abandons the partial frame
                        // and restarts with this word as slot 0.
                        error_set = (slot_q != 3'd0);
                        slot_d    = 3'd1;
                        load_word = 1'b1;
                        load_slot = 3'd0;
                    end else if (slot_q == 3'd0) begin
                        error_set = 1'b1;
                        state_d   = HUNT;
                        slot_d    = 3'd0;
                    end else if (slot_q == 3'd7) begin
                        frame_done = 1'b1;
                        slot_d     = 3'd0;
                    end else begin
                        load_word = 1'b1;
                        slot_d    = slot_q + 3'd1;
                    end
                end
                default: begin
                    state_d = HUNT;
                    slot_d  = 3'd0;
                end
            endcase
        end
    end

    // Shadow registers collect slots 0..6 of the frame under construction.
    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            for (int k = 0; k < 7; k++) shadow_q[k] <= '0;
        end else begin
            for (int k = 0; k < 7; k++) begin
                if (load_word && load_slot == 3'(k)) shadow_q[k] <= Data_In;
            end
        end
    end

    // Channel outputs publish a whole frame at once on the slot-7 capture.
    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            for (int k = 0; k < 8; k++) data_q[k] <= '0;
            frame_valid_q <= 1'b0;
        end else begin
            if (frame_done) begin
                for (int k = 0; k < 7; k++) data_q[k] <= shadow_q[k];
                data_q[7] <= Data_In;
            end
            frame_valid_q <= frame_done;
        end
    end

    // Sticky error flag; a new error on the same edge as a clear wins.
    always_ff @(posedge Clock_In) begin
        if (Reset_In) begin
            sync_error_q <= 1'b0;
        end else if (error_set) begin
            sync_error_q <= 1'b1;
        end else if (Clear_Error_In) begin
            sync_error_q <= 1'b0;
        end
    end

    // Output decode from registered state.
    always_comb begin
        Locked_Out      = (state_q == LOCKED);
        Slot_Out        = slot_q;
        Frame_Valid_Out = frame_valid_q;
        Sync_Error_Out  = sync_error_q;
    end

    assign Data_0_Out = data_q[0];
    assign Data_1_Out = data_q[1];
    assign Data_2_Out = data_q[2];
    assign Data_3_Out = data_q[3];
    assign Data_4_Out = data_q[4];
    assign Data_5_Out = data_q[5];
    assign Data_6_Out = data_q[6];
    assign Data_7_Out = data_q[7];

endmodule

// File: tb/tb_tdm_demux_1_8.sv
// Testbench for tdm_demux_1_8: a table of hand-derived vectors, hand-written
// framing corner cases, and randomized traffic checked against a frame-level
// reference model.

module tb_tdm_demux_1_8;

    logic       clk = 1'b0;
    logic       rst, en, dv, fs, clr;
    logic [7:0] din;
    logic [7:0] d0, d1, d2, d3, d4, d5, d6, d7;
    logic       fv, locked, err;
    logic [2:0] slot;
    logic [7:0] dut_data [8];

    int n_vectors     = 0;
    int n_miscompares = 0;

    always #5 clk = ~clk;

    tdm_demux_1_8 #(.DATA_WIDTH(8)) dut (
        .Clock_In(clk), .Reset_In(rst), .Enable_In(en), .Data_In(din),
        .Data_Valid_In(dv), .Frame_Sync_In(fs), .Clear_Error_In(clr),
        .Data_0_Out(d0), .Data_1_Out(d1), .Data_2_Out(d2), .Data_3_Out(d3),
        .Data_4_Out(d4), .Data_5_Out(d5), .Data_6_Out(d6), .Data_7_Out(d7),
        .Frame_Valid_Out(fv), .Locked_Out(locked), .Slot_Out(slot),
        .Sync_Error_Out(err)
    );

    assign dut_data[0] = d0;
    assign dut_data[1] = d1;
    assign dut_data[2] = d2;
    assign dut_data[3] = d3;
    assign dut_data[4] = d4;
    assign dut_data[5] = d5;
    assign dut_data[6] = d6;
    assign dut_data[7] = d7;

    // Reference model: the frame under construction is a queue of words;
    // its length is the next slot index.
    bit         m_locked;
    logic [7:0] m_frame[$];
    logic [7:0] m_out [8];
    bit         m_fv;
    bit         m_err;

    function automatic void modelEdge(bit r, bit e, bit v, bit s, bit c, logic [7:0] d);
        bit set;
        set = 0;
        if (r) begin
            m_locked = 0;
            m_frame.delete();
            for (int k = 0; k < 8; k++) m_out[k] = 8'h00;
            m_fv  = 0;
            m_err = 0;
            return;
        end
        m_fv = 0;
        if (e && v) begin
            if (s) begin
                if (m_locked && m_frame.size() != 0) set = 1;
                m_frame.delete();
                m_frame.push_back(d);
                m_locked = 1;
            end else if (m_locked) begin
                if (m_frame.size() == 0) begin
                    set      = 1;
                    m_locked = 0;
                end else begin
                    m_frame.push_back(d);
                    if (m_frame.size() == 8) begin
                        for (int k = 0; k < 8; k++) m_out[k] = m_frame[k];
                        m_fv = 1;
                        m_frame.delete();
                    end
                end
            end
        end
        if (set) m_err = 1;
        else if (c) m_err = 0;
    endfunction

    bit vec_bad;

    task automatic checkField(input string name, input int act, input int exp);
        if (act != exp) begin
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
            vec_bad = 1;
        end
    endtask

    // Drive one cycle of inputs, let the edge happen, then sample shortly after.
    task automatic applyStimulus(input bit r, input bit e, input bit v, input bit s,
                                 input bit c, input logic [7:0] d);
        @(negedge clk);
        rst = r; en = e; dv = v; fs = s; clr = c; din = d;
        @(posedge clk);
        modelEdge(r, e, v, s, c, d);
        #1;
    endtask

    // Compare every output against the reference model.
    task automatic checkOutput(input string tag);
        vec_bad = 0;
        n_vectors++;
        checkField({tag, ".frame_valid"}, int'(fv), int'(m_fv));
        checkField({tag, ".locked"}, int'(locked), int'(m_locked));
        checkField({tag, ".slot"}, int'(slot), m_frame.size());
        checkField({tag, ".sync_error"}, int'(err), int'(m_err));
        for (int k = 0; k < 8; k++)
            checkField($sformatf("%s.data%0d", tag, k), int'(dut_data[k]), int'(m_out[k]));
        if (vec_bad) n_miscompares++;
    endtask

    task automatic step(input string tag, input bit r, input bit e, input bit v,
                        input bit s, input bit c, input logic [7:0] d);
        applyStimulus(r, e, v, s, c, d);
        checkOutput(tag);
    endtask

    typedef struct {
        bit         rst, en, dv, fs, clr;
        logic [7:0] data;
        bit         exp_fv, exp_lock, exp_err;
        logic [2:0] exp_slot;
        logic [7:0] exp_d0, exp_d7;
    } vec_t;

    vec_t tbl [$];

    initial begin
        rst = 1; en = 0; dv = 0; fs = 0; clr = 0; din = 8'h00;

        // Plan 1: reset then eight back-to-back captures 0x10..0x17.
        tbl.push_back('{1,1,0,0,0,8'h00, 0,0,0,3'd0,8'h00,8'h00});
        tbl.push_back('{0,1,1,1,0,8'h10, 0,1,0,3'd1,8'h00,8'h00});
        for (int i = 1; i < 7; i++)
            tbl.push_back('{0,1,1,0,0,8'(8'h10 + i), 0,1,0,3'(i + 1),8'h00,8'h00});
        tbl.push_back('{0,1,1,0,0,8'h17, 1,1,0,3'd0,8'h10,8'h17});
        tbl.push_back('{0,1,0,0,0,8'h00, 0,1,0,3'd0,8'h10,8'h17});
        // Plan 2: reset, three unsynced words in HUNT, then frame 0xA0..0xA7.
        tbl.push_back('{1,1,0,0,0,8'h00, 0,0,0,3'd0,8'h00,8'h00});
        for (int i = 0; i < 3; i++)
            tbl.push_back('{0,1,1,0,0,8'(8'h50 + i), 0,0,0,3'd0,8'h00,8'h00});
        tbl.push_back('{0,1,1,1,0,8'hA0, 0,1,0,3'd1,8'h00,8'h00});
        for (int i = 1; i < 7; i++)
            tbl.push_back('{0,1,1,0,0,8'(8'hA0 + i), 0,1,0,3'(i + 1),8'h00,8'h00});
        tbl.push_back('{0,1,1,0,0,8'hA7, 1,1,0,3'd0,8'hA0,8'hA7});
        tbl.push_back('{0,1,0,0,0,8'h00, 0,1,0,3'd0,8'hA0,8'hA7});

        foreach (tbl[i]) begin
            applyStimulus(tbl[i].rst, tbl[i].en, tbl[i].dv, tbl[i].fs, tbl[i].clr, tbl[i].data);
            vec_bad = 0;
            n_vectors++;
            checkField($sformatf("tbl%0d.frame_valid", i), int'(fv), int'(tbl[i].exp_fv));
            checkField($sformatf("tbl%0d.locked", i), int'(locked), int'(tbl[i].exp_lock));
            checkField($sformatf("tbl%0d.slot", i), int'(slot), int'(tbl[i].exp_slot));
            checkField($sformatf("tbl%0d.sync_error", i), int'(err), int'(tbl[i].exp_err));
            checkField($sformatf("tbl%0d.data0", i), int'(d0), int'(tbl[i].exp_d0));
            checkField($sformatf("tbl%0d.data7", i), int'(d7), int'(tbl[i].exp_d7));
            if (vec_bad) n_miscompares++;
        end

        // Plan 3: frame 0x20..0x27 with gaps and a 4-cycle enable drop mid-frame.
        for (int i = 0; i < 8; i++) begin
            step("gap", 0, 1, 1, (i == 0), 0, 8'(8'h20 + i));
            step("gap_idle", 0, 1, 0, 0, 0, 8'hEE);
            if (i == 3)
                for (int j = 0; j < 4; j++) step("disabled", 0, 0, 1, (j == 1), 0, 8'hDD);
        end
        step("gap_after", 0, 1, 0, 0, 0, 8'h00);

        // Plan 4: early sync at slot 4, then a full frame 0x30..0x37.
        for (int i = 0; i < 4; i++) step("partial", 0, 1, 1, (i == 0), 0, 8'(8'h60 + i));
        for (int i = 0; i < 8; i++) step("early", 0, 1, 1, (i == 0), 0, 8'(8'h30 + i));
        step("early_after", 0, 1, 0, 0, 0, 8'h00);

        // Plan 5: missing sync, clear, then a clear coincident with a new error.
        step("clr0", 0, 1, 0, 0, 1, 8'h00);
        for (int i = 0; i < 8; i++) step("good", 0, 1, 1, (i == 0), 0, 8'(8'h70 + i));
        step("missing", 0, 1, 1, 0, 0, 8'h55);
        step("clear", 0, 1, 0, 0, 1, 8'h00);
        step("relock", 0, 1, 1, 1, 0, 8'h01);
        step("clr_vs_err", 0, 1, 1, 1, 1, 8'h02);
        step("held", 0, 0, 0, 0, 0, 8'h00);
        step("clr_disabled", 0, 0, 1, 0, 1, 8'h03);

        // Plan 6: reset at slot 5, then frame 0x40..0x47.
        for (int i = 0; i < 8; i++) step("pre", 0, 1, 1, (i == 0), 0, 8'(8'h90 + i));
        for (int i = 0; i < 5; i++) step("pre_rst", 0, 1, 1, (i == 0), 0, 8'(8'hB0 + i));
        step("mid_reset", 1, 1, 1, 0, 0, 8'hB5);
        for (int i = 0; i < 8; i++) step("post_rst", 0, 1, 1, (i == 0), 0, 8'(8'h40 + i));
        step("post_idle", 0, 1, 0, 0, 0, 8'h00);

        // Randomized traffic: mostly well-formed frames with occasional faults.
        for (int i = 0; i < 3000; i++) begin
            bit r, e, v, s, c;
            r = ($urandom_range(0, 199) == 0);
            e = ($urandom_range(0, 9) != 0);
            v = ($urandom_range(0, 4) != 0);
            if (m_frame.size() == 0) s = ($urandom_range(0, 9) != 0);
            else                     s = ($urandom_range(0, 29) == 0);
            c = ($urandom_range(0, 19) == 0);
            step("rand", r, e, v, s, c, 8'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vectors, n_miscompares);
        $finish;
    end

endmodule

// File: doc/tdm_demux_1_8.md
Name: tdm_demux_1_8

Overview:
Time-division 1:8 demultiplexer. It is the receive-side counterpart of the 8:1 MUX datapath. A serial word stream carries eight slots per frame, and Frame_Sync_In marks slot 0. The block steers each valid word into a per-slot shadow register and publishes all eight channels in parallel, with a one-cycle frame strobe, once slot 7 arrives. It sits after the TDM link front end and feeds per-channel consumers.

Parameters:
DATA_WIDTH, 8, width of each slot word and of each channel output.

Ports:
Clock_In  input  1  system clock; all logic is rising-edge.
Reset_In  input  1  synchronous, active-high reset.
Enable_In  input  1  when low, the block freezes (see Behaviour).
Data_In  input  DATA_WIDTH  slot word from the TDM stream.
Data_Valid_In  input  1  Data_In is valid this cycle.
Frame_Sync_In  input  1  qualifies the current valid word as slot 0; ignored when Data_Valid_In=0.
Clear_Error_In  input  1  clears Sync_Error_Out.
Data_0_Out .. Data_7_Out  output  DATA_WIDTH each  registered channel words of the last complete frame.
Frame_Valid_Out  output  1  one-cycle pulse when Data_k_Out update.
Locked_Out  output  1  high in the LOCKED state.
Slot_Out  output  3  slot index the next valid word will occupy.
Sync_Error_Out  output  1  sticky framing-error flag.

Behaviour:
- One clock; reset is synchronous and active-high. Reset_In is sampled on the rising edge of Clock_In and overrides all other inputs.
- Reset values:
  - state=HUNT, Slot_Out=0.
  - All Data_k_Out=0, and all shadow registers=0.
  - Frame_Valid_Out=0, Locked_Out=0, Sync_Error_Out=0.
- Reset asserted mid-frame discards the partial frame. Data_k_Out are cleared to 0.
- A "capture" is an edge where Enable_In=1 and Data_Valid_In=1.
- Enable_In=0 behaviour:
  - No capture occurs.
  - State, Slot_Out, shadow registers and outputs hold.
  - Frame_Valid_Out=0.
  - Clear_Error_In is still honoured.
- HUNT state:
  - A capture with Frame_Sync_In=0 is discarded. Slot_Out stays 0.
  - A capture with Frame_Sync_In=1 writes shadow[0]=Data_In, sets Slot_Out=1 and moves to LOCKED.
- LOCKED, capture with Frame_Sync_In=0 and Slot_Out=s, where 1<=s<=6: shadow[s]=Data_In, Slot_Out=s+1.
- LOCKED, capture with Frame_Sync_In=0 and s=7: completes the frame on that same edge.
  - Data_0_Out..Data_6_Out load from shadow[0..6], and Data_7_Out loads Data_In.
  - Frame_Valid_Out=1 for exactly the following cycle.
  - Slot_Out wraps to 0.
  - State stays LOCKED.
- LOCKED, capture with s=0 and Frame_Sync_In=1: normal frame start. shadow[0]=Data_In, Slot_Out=1.
- LOCKED, capture with s=0 and Frame_Sync_In=0: missing sync.
  - Sync_Error_Out is set and the word is discarded.
  - State goes to HUNT with Slot_Out=0.
- LOCKED, capture with s in 1..7 and Frame_Sync_In=1: early sync.
  - Sync_Error_Out is set and the partial frame is discarded (no Frame_Valid_Out).
  - The word is taken as slot 0 (shadow[0]=Data_In, Slot_Out=1). State stays LOCKED.
- Error flag:
  - Sync_Error_Out is sticky until Clear_Error_In=1 at an edge.
  - If an error is detected on the same edge as Clear_Error_In, set wins.
- Outputs:
  - Data_k_Out change only on a completing capture. Between frames they hold the last complete frame.
  - Latency from the slot-7 capture edge to Data_k_Out/Frame_Valid_Out visible is 0 edges (registered on that edge).
- Back-to-back valid words every cycle are supported with no bubbles. Gaps (Data_Valid_In=0) inside a frame are allowed and hold Slot_Out.
- Locked_Out is a registered state decode: 1 in LOCKED, 0 in HUNT.

Test Plan:
- Reset, then 8 consecutive captures 0x10..0x17 with sync on the first word -> Data_0_Out..Data_7_Out=0x10..0x17; Frame_Valid_Out high one cycle; Locked_Out=1; Slot_Out=0.
- In HUNT, 3 words without sync, then a synced frame 0xA0..0xA7 -> first 3 words are ignored; outputs=0xA0..0xA7; Sync_Error_Out=0.
- Frame 0x20..0x27 with Data_Valid_In low on alternate cycles and Enable_In low for 4 cycles mid-frame -> outputs=0x20..0x27 after the 8th capture; no strobe while Enable_In=0.
- Early sync at slot 4, then a full frame 0x30..0x37 -> no strobe for the partial frame; Sync_Error_Out=1; outputs=0x30..0x37; Locked_Out stays 1.
- After a good frame, a word 0x55 without sync at slot 0 -> Sync_Error_Out=1; Locked_Out=0; outputs keep the prior frame. Clear_Error_In pulse -> 0; clear coincident with a new error -> flag stays 1.
- Reset_In asserted at slot 5 -> next cycle all outputs 0; state HUNT; following synced frame 0x40..0x47 decoded correctly.
